// File: rtl/unified_mem_arbiter.sv
// Shares one single-port, 1-cycle-read-latency memory between instruction fetch (I) and load/store (D).
// Optional MEM_ARB_STARVE_GUARD_EN bounds how many consecutive D grants can hold off a pending I request.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [3:0]            d_be,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_enable,
    output logic                  mem_we,
    output logic [3:0]            mem_byte_enable,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    owner_t r_resp_owner;
    owner_t w_resp_owner_next;
    logic   w_force_i;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int                  STREAK_W   = $clog2(MAX_D_BURST + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_BURST);

    logic [STREAK_W-1:0] r_d_streak;
    logic [STREAK_W-1:0] w_d_streak_next;

    assign w_force_i = (r_d_streak == STREAK_MAX);

    // Counts D grants that overtook a waiting I; any I grant or idle I cycle restarts the count.
    always_comb begin
        w_d_streak_next = r_d_streak;
        if (!i_req || i_gnt) begin
            w_d_streak_next = '0;
        end else if (d_gnt && (r_d_streak != STREAK_MAX)) begin
            w_d_streak_next = r_d_streak + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_d_streak <= '0;
        end else begin
            r_d_streak <= w_d_streak_next;
        end
    end
`else
    assign w_force_i = 1'b0;

    // MAX_D_BURST only shapes arbitration when the guard is built in.
    if (MAX_D_BURST < 1) begin : g_max_d_burst_unused
    end
`endif

    assign d_gnt = d_req & ~(i_req & w_force_i);
    assign i_gnt = i_req & ~d_gnt;

    always_comb begin
        mem_enable      = 1'b0;
        mem_we          = 1'b0;
        mem_byte_enable = 4'b0000;
        mem_address     = '0;
        mem_write_data  = '0;
        if (d_gnt) begin
            mem_enable      = 1'b1;
            mem_we          = d_we;
            mem_byte_enable = d_be;
            mem_address     = d_addr;
            mem_write_data  = d_wdata;
        end else if (i_gnt) begin
            mem_enable      = 1'b1;
            mem_byte_enable = 4'b1111;
            mem_address     = i_addr;
        end
    end

    // The owner of next cycle's read data is whoever was granted a read this cycle.
    always_comb begin
        w_resp_owner_next = OWN_NONE;
        if (d_gnt && !d_we) begin
            w_resp_owner_next = OWN_D;
        end else if (i_gnt) begin
            w_resp_owner_next = OWN_I;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp_owner <= OWN_NONE;
        end else begin
            r_resp_owner <= w_resp_owner_next;
        end
    end

    assign i_rvalid = (r_resp_owner == OWN_I);
    assign d_rvalid = (r_resp_owner == OWN_D);
    assign i_rdata  = i_rvalid ? mem_read_data : '0;
    assign d_rdata  = d_rvalid ? mem_read_data : '0;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: combinational table, directed sequences, randomized traffic.
module tb_unified_mem_arbiter;

    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int MAXB = 4;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt;
    logic          i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req;
    logic          d_we;
    logic [3:0]    d_be;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_enable;
    logic          mem_we;
    logic [3:0]    mem_byte_enable;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data = '0;

    logic [DW-1:0] tb_mem  [0:4095];
    logic [DW-1:0] ref_mem [0:4095];

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: pending response owner (0 none, 1 I, 2 D), its data, guard streak.
    int          m_pend = 0;
    logic [31:0] m_pdata = '0;
    int          m_streak = 0;
    logic        m_last_i_gnt = 1'b0;
    logic        m_last_d_gnt = 1'b0;

    unified_mem_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MAX_D_BURST(MAXB)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .i_req          (i_req),
        .i_addr         (i_addr),
        .i_gnt          (i_gnt),
        .i_rvalid       (i_rvalid),
        .i_rdata        (i_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_be           (d_be),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_gnt          (d_gnt),
        .d_rvalid       (d_rvalid),
        .d_rdata        (d_rdata),
        .mem_enable     (mem_enable),
        .mem_we         (mem_we),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always #5 clock = ~clock;

    // Single-port memory, 1-cycle read latency, byte-enabled writes.
    always @(posedge clock) begin
        if (mem_enable && reset_n) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byte_enable[b]) tb_mem[mem_address][8*b +: 8] <= mem_write_data[8*b +: 8];
            end else begin
                mem_read_data <= tb_mem[mem_address];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: inputs already driven after a negedge; checks, then advances the model.
    task automatic step();
        logic        e_d, e_i, e_en, e_we;
        logic [3:0]  e_be;
        logic [11:0] e_a;
        logic [31:0] e_wd;
        #1;
        e_d  = d_req && !(GUARD && i_req && (m_streak == MAXB));
        e_i  = i_req && !e_d;
        e_en = e_i || e_d;
        e_we = e_d && d_we;
        e_be = e_d ? d_be : (e_i ? 4'hF : 4'h0);
        e_a  = e_d ? d_addr : (e_i ? i_addr : 12'h000);
        e_wd = e_d ? d_wdata : 32'h0;
        check("i_gnt", 32'(i_gnt), 32'(e_i));
        check("d_gnt", 32'(d_gnt), 32'(e_d));
        check("mem_enable", 32'(mem_enable), 32'(e_en));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_byte_enable", 32'(mem_byte_enable), 32'(e_be));
        check("mem_address", 32'(mem_address), 32'(e_a));
        check("mem_write_data", mem_write_data, e_wd);
        check("i_rvalid", 32'(i_rvalid), 32'(m_pend == 1));
        check("d_rvalid", 32'(d_rvalid), 32'(m_pend == 2));
        check("i_rdata", i_rdata, (m_pend == 1) ? m_pdata : 32'h0);
        check("d_rdata", d_rdata, (m_pend == 2) ? m_pdata : 32'h0);
        @(posedge clock);
        if (!reset_n) begin
            m_pend   = 0;
            m_streak = 0;
        end else begin
            if (e_d && d_we) begin
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
                m_pend = 0;
            end else if (e_d) begin
                m_pend  = 2;
                m_pdata = ref_mem[d_addr];
            end else if (e_i) begin
                m_pend  = 1;
                m_pdata = ref_mem[i_addr];
            end else begin
                m_pend = 0;
            end
            if (!i_req || e_i) m_streak = 0;
            else if (e_d && m_streak < MAXB) m_streak++;
        end
        m_last_i_gnt = e_i;
        m_last_d_gnt = e_d;
        @(negedge clock);
    endtask

    typedef struct {
        logic        i_req;
        logic [11:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [3:0]  d_be;
        logic [11:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_i_gnt;
        logic        e_d_gnt;
        logic        e_en;
        logic        e_we;
        logic [3:0]  e_be;
        logic [11:0] e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vt [7];

    logic [9:0] pat;
    logic [9:0] pat_exp;

    initial begin
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i]  = 32'(i) * 32'h9E3779B1;
            ref_mem[i] = 32'(i) * 32'h9E3779B1;
        end
        tb_mem[12'h010] = 32'h00500093; ref_mem[12'h010] = 32'h00500093;
        tb_mem[12'h100] = 32'hDEADBEEF; ref_mem[12'h100] = 32'hDEADBEEF;
        tb_mem[12'h200] = 32'h00000000; ref_mem[12'h200] = 32'h00000000;

        vt[0] = '{1'b0, 12'h123, 1'b0, 1'b1, 4'hF, 12'h456, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 12'h000, 32'h0};
        vt[1] = '{1'b1, 12'h010, 1'b0, 1'b1, 4'h3, 12'h200, 32'h00001111, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'h010, 32'h0};
        vt[2] = '{1'b0, 12'h010, 1'b1, 1'b0, 4'hF, 12'h100, 32'h00002222, 1'b0, 1'b1, 1'b1, 1'b0, 4'hF, 12'h100, 32'h00002222};
        vt[3] = '{1'b0, 12'h010, 1'b1, 1'b1, 4'h3, 12'h200, 32'h1234ABCD, 1'b0, 1'b1, 1'b1, 1'b1, 4'h3, 12'h200, 32'h1234ABCD};
        vt[4] = '{1'b1, 12'h020, 1'b1, 1'b0, 4'hC, 12'hFFF, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 4'hC, 12'hFFF, 32'h0};
        vt[5] = '{1'b1, 12'h030, 1'b1, 1'b1, 4'h8, 12'h004, 32'hCAFEF00D, 1'b0, 1'b1, 1'b1, 1'b1, 4'h8, 12'h004, 32'hCAFEF00D};
        vt[6] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 4'h1, 12'h000, 32'h55555555, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 12'hFFF, 32'h0};

        reset_n = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = '0; d_wdata = '0;
        @(negedge clock);

        // Arbitration table applied while held in reset: grants still follow the rules, no rvalid.
        foreach (vt[k]) begin
            i_req = vt[k].i_req; i_addr = vt[k].i_addr;
            d_req = vt[k].d_req; d_we = vt[k].d_we; d_be = vt[k].d_be;
            d_addr = vt[k].d_addr; d_wdata = vt[k].d_wdata;
            #1;
            check("tbl_i_gnt", 32'(i_gnt), 32'(vt[k].e_i_gnt));
            check("tbl_d_gnt", 32'(d_gnt), 32'(vt[k].e_d_gnt));
            check("tbl_mem_enable", 32'(mem_enable), 32'(vt[k].e_en));
            check("tbl_mem_we", 32'(mem_we), 32'(vt[k].e_we));
            check("tbl_mem_byte_enable", 32'(mem_byte_enable), 32'(vt[k].e_be));
            check("tbl_mem_address", 32'(mem_address), 32'(vt[k].e_addr));
            check("tbl_mem_write_data", mem_write_data, vt[k].e_wdata);
            check("tbl_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
            @(negedge clock);
        end

        // Reset with both requests, then conflict: D read wins, I follows once D drops.
        i_req = 1'b1; i_addr = 12'h010;
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 12'h100; d_wdata = '0;
        #1;
        check("rst_d_gnt", 32'(d_gnt), 32'h1);
        check("rst_i_gnt", 32'(i_gnt), 32'h0);
        check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        step();
        d_req = 1'b0;
        #1;
        check("conflict_d_rvalid", 32'(d_rvalid), 32'h1);
        check("conflict_d_rdata", d_rdata, 32'hDEADBEEF);
        check("conflict_i_gnt", 32'(i_gnt), 32'h1);
        step();

        // I-only read of 0x010 (the conflict's I grant also fetched it).
        i_req = 1'b1; i_addr = 12'h010;
        step();
        i_req = 1'b0;
        #1;
        check("ifetch_i_rvalid", 32'(i_rvalid), 32'h1);
        check("ifetch_i_rdata", i_rdata, 32'h00500093);
        check("ifetch_d_rvalid", 32'(d_rvalid), 32'h0);
        step();

        // Half-word store, then read back.
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011; d_addr = 12'h200; d_wdata = 32'h1234ABCD;
        #1;
        check("store_mem_we", 32'(mem_we), 32'h1);
        check("store_mem_be", 32'(mem_byte_enable), 32'h3);
        step();
        d_we = 1'b0; d_be = 4'hF;
        #1;
        check("store_no_rvalid", 32'(d_rvalid), 32'h0);
        step();
        d_req = 1'b0;
        #1;
        check("store_readback", d_rdata, 32'h0000ABCD);
        step();

        // Sustained contention for 10 cycles.
        step();
        i_req = 1'b1; i_addr = 12'h014; d_req = 1'b1; d_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            d_addr = 12'(12'h040 + k);
            #1;
            pat[9-k] = d_gnt;
            step();
        end
        pat_exp = GUARD ? 10'b1111011110 : 10'b1111111111;
        check("guard_pattern", 32'(pat), 32'(pat_exp));
        i_req = 1'b0; d_req = 1'b0;
        step();

        // Reset pulse while a D read response is outstanding.
        d_req = 1'b1; d_we = 1'b0; d_addr = 12'h100;
        step();
        d_req = 1'b0;
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_d_rvalid_low", 32'(d_rvalid), 32'h0);
        reset_n = 1'b1;
        m_pend = 0; m_streak = 0;
        #1;
        check("midrst_d_rvalid_after", 32'(d_rvalid), 32'h0);
        step();

        // Randomized traffic; requesters hold payload until granted.
        for (int k = 0; k < 400; k++) begin
            if (!(i_req && !m_last_i_gnt)) begin
                i_req  = ($urandom_range(0, 99) < 60);
                i_addr = 12'($urandom_range(0, 31));
            end
            if (!(d_req && !m_last_d_gnt)) begin
                d_req   = ($urandom_range(0, 99) < 55);
                d_we    = 1'($urandom_range(0, 1));
                d_be    = 4'($urandom_range(1, 15));
                d_addr  = 12'($urandom_range(0, 31));
                d_wdata = $urandom;
            end
            if ($urandom_range(0, 59) == 0) begin
                reset_n = 1'b0;
                #1;
                reset_n = 1'b1;
                m_pend = 0; m_streak = 0;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
